// File: rtl/simple_axi_to_axi_read.sv
// Byte-length read requests become AXI INCR bursts. Bursts are split at 256 beats and
// at 4 KB boundaries, and R beats are passed straight through to the consumer.
module simple_axi_to_axi_read #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 4,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_rvalid,
  input  logic [AXI_ADDR_W-1:0] m_raddr,
  input  logic [LEN_W-1:0]      m_rlen,
  output logic                  m_rready,
  output logic [AXI_DATA_W-1:0] m_rdata,
  input  logic                  m_racc,
  output logic                  m_rlast,
  output logic [AXI_ID_W-1:0]   m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [AXI_LEN_W-1:0]  m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [1:0]            m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_ID_W-1:0]   m_axi_rid,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int BPW = AXI_DATA_W / 8;
  localparam int SZ  = $clog2(BPW);

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DONE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q, addr_d, rem_q, rem_d, burst_q, burst_d, araddr_q, araddr_d;
  logic [AXI_LEN_W-1:0]   arlen_q, arlen_d, beat_q, beat_d;
  logic [31:0]            start_addr, words, to_4k, b_lim, b_calc;
  logic                   beat, burst_end, final_beat;
  logic                   unused_in;

  assign start_addr = (32'(m_raddr) >> SZ) << SZ;
  assign words      = (32'(m_rlen) + 32'(BPW - 1)) >> SZ;
  // Words left before the next 4 KB page; the address is always word aligned here.
  assign to_4k      = (32'd4096 - {20'd0, addr_q[11:0]}) >> SZ;
  assign b_lim      = (rem_q > 32'd256) ? 32'd256 : rem_q;
  assign b_calc     = (b_lim > to_4k) ? to_4k : b_lim;
  assign beat       = (state_q == DATA) && m_axi_rvalid && m_racc;
  assign burst_end  = beat && (beat_q == arlen_q);
  assign final_beat = burst_end && (rem_q == burst_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    burst_d  = burst_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: if (m_rvalid) begin
        addr_d  = start_addr;
        rem_d   = words;
        state_d = (words == 32'd0) ? DONE : CALC;
      end
      CALC: begin
        burst_d  = b_calc;
        araddr_d = addr_q;
        arlen_d  = AXI_LEN_W'(b_calc - 32'd1);
        state_d  = ADDR;
      end
      ADDR: if (m_axi_arready) begin
        beat_d  = '0;
        state_d = DATA;
      end
      DATA: begin
        if (beat) beat_d = beat_q + AXI_LEN_W'(1);
        if (burst_end) begin
          addr_d  = addr_q + (burst_q << SZ);
          rem_d   = rem_q - burst_q;
          state_d = final_beat ? IDLE : CALC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      burst_q  <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      burst_q  <= burst_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      beat_q   <= beat_d;
    end
  end

  // R-channel ID, response and last are not needed: burst end comes from the beat count.
  assign unused_in = ^{m_axi_rid, m_axi_rresp, m_axi_rlast};

  assign m_rready      = (state_q == DATA) && m_axi_rvalid;
  assign m_axi_rready  = (state_q == DATA) && m_racc;
  assign m_rdata       = m_axi_rdata;
  assign m_rlast       = final_beat || (state_q == DONE);
  assign m_axi_arvalid = (state_q == ADDR);
  assign m_axi_araddr  = AXI_ADDR_W'(araddr_q);
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = 4'h2;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arqos   = 4'h0;
endmodule
